pipelined_shifter: RTL and testbench

- Parametrised, pipelined successor to the ALU's combinational SLL barrel shifter.
- Supports four modes: logical left, logical right, arithmetic right and rotate left, at configurable data width.
- Barrel levels are split across a configurable number of register stages, with valid/ready flow control and an opaque tag carried alongside each operation.
- Sits in the execute stage as a multi-cycle shift unit feeding the writeback mux.

---
 rtl/shifter_pkg.sv | 34 +++
 rtl/shift_level.sv | 39 +++
 rtl/pipelined_shifter.sv | 103 ++++++++++
 tb/tb_pipelined_shifter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared op encodings, clog2 helper and stage control record
//               for the pipelined barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width-independent part of a stage record; data/amt/tag are sized by the top.
    typedef struct packed {
        logic       valid;
        logic [1:0] op;
        logic       sign;
    } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One barrel level: shifts or rotates by 2^K when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_op,
    input  logic             i_sign,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_S = 1 << K;

    logic [WIDTH-1:0] w_shifted;

    // SRA fills from the sign captured at entry, since earlier levels may
    // already have moved the original MSB.
    always_comb begin
        w_shifted = i_data;
        case (i_op)
            SH_SLL:  w_shifted = {i_data[WIDTH-1-c_S:0], {c_S{1'b0}}};
            SH_SRL:  w_shifted = {{c_S{1'b0}}, i_data[WIDTH-1:c_S]};
            SH_SRA:  w_shifted = {{c_S{i_sign}}, i_data[WIDTH-1:c_S]};
            default: w_shifted = {i_data[WIDTH-1-c_S:0], i_data[WIDTH-1:WIDTH-c_S]};
        endcase
    end

    assign o_data = i_en ? w_shifted : i_data;

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shifter
// Description : Pipelined SLL/SRL/SRA/ROL barrel shifter with global-stall
//               valid/ready flow control and tag passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAGW-1:0]          out_tag
);

    localparam int c_L = clog2(WIDTH);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] data;
        logic [c_L-1:0]   amt;
        logic [TAGW-1:0]  tag;
    } stage_t;

    stage_t r_stage [STAGES];
    stage_t w_src   [STAGES];
    stage_t w_next  [STAGES];
    logic   w_adv;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            localparam int c_LO = (s * c_L) / STAGES;
            localparam int c_HI = ((s + 1) * c_L) / STAGES - 1;

            if (s == 0) begin : g_entry
                assign w_src[s] = '{ctl:  '{valid: in_valid, op: in_op, sign: in_data[WIDTH-1]},
                                    data: in_data, amt: in_amt, tag: in_tag};
            end else begin : g_chain
                assign w_src[s] = r_stage[s-1];
            end

            for (genvar k = c_LO; k <= c_HI; k++) begin : g_level
                logic [WIDTH-1:0] w_lvl_in;
                logic [WIDTH-1:0] w_lvl_out;

                if (k == c_LO) begin : g_first
                    assign w_lvl_in = w_src[s].data;
                end else begin : g_inner
                    assign w_lvl_in = g_level[k-1].w_lvl_out;
                end

                shift_level #(
                    .WIDTH (WIDTH),
                    .K     (k)
                ) u_level (
                    .i_data (w_lvl_in),
                    .i_op   (w_src[s].ctl.op),
                    .i_sign (w_src[s].ctl.sign),
                    .i_en   (w_src[s].amt[k]),
                    .o_data (w_lvl_out)
                );
            end

            assign w_next[s] = '{ctl: w_src[s].ctl, data: g_level[c_HI].w_lvl_out,
                                 amt: w_src[s].amt, tag: w_src[s].tag};
        end
    endgenerate

    // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
    assign w_adv = ~r_stage[STAGES-1].ctl.valid | out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else if (w_adv) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= w_next[s];
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_stage[STAGES-1].ctl.valid;
    assign out_data  = r_stage[STAGES-1].data;
    assign out_tag   = r_stage[STAGES-1].tag;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_shifter
// Description : Self-checking bench: directed vector table, stream, stall,
//               reset and parameter-sweep sequences against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;
    import shifter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_amt, in_tag, out_tag;
    logic [1:0]  in_op;

    logic        s_valid;
    logic [31:0] s_data;
    logic [4:0]  s_amt, s_tag;
    logic [1:0]  s_op;
    logic        i1_ready, o1_valid, i5_ready, o5_valid, i8_ready, o8_valid;
    logic [31:0] o1_data, o5_data;
    logic [7:0]  o8_data;
    logic [4:0]  o1_tag, o5_tag, o8_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out, n1, n5, n8;
    int cyc = 0;
    bit sb_en = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [12];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        int          cyc;
    } sb_t;
    sb_t q_main[$], q1[$], q5[$], q8[$];

    pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAGW(5)) u_dut (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

    pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAGW(5)) u_dut_s1 (
        .clock(clk), .reset(rst), .in_valid(s_valid), .in_ready(i1_ready),
        .in_data(s_data), .in_amt(s_amt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(o1_valid), .out_ready(1'b1), .out_data(o1_data), .out_tag(o1_tag));

    pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAGW(5)) u_dut_s5 (
        .clock(clk), .reset(rst), .in_valid(s_valid), .in_ready(i5_ready),
        .in_data(s_data), .in_amt(s_amt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(o5_valid), .out_ready(1'b1), .out_data(o5_data), .out_tag(o5_tag));

    pipelined_shifter #(.WIDTH(8), .STAGES(3), .TAGW(5)) u_dut_w8 (
        .clock(clk), .reset(rst), .in_valid(s_valid), .in_ready(i8_ready),
        .in_data(s_data[7:0]), .in_amt(s_amt[2:0]), .in_op(s_op), .in_tag(s_tag),
        .out_valid(o8_valid), .out_ready(1'b1), .out_data(o8_data), .out_tag(o8_tag));

    function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int w,
                                              input int a, input logic [1:0] op);
        logic [63:0] mask, d, r;
        mask = (64'h1 << w) - 64'h1;
        d    = d_in & mask;
        case (op)
            2'b00:   r = (d << a) & mask;
            2'b01:   r = d >> a;
            2'b10:   r = (d >> a) | (d[w-1] ? (mask & ~(mask >> a)) : 64'h0);
            default: r = ((d << a) | (d >> (w - a))) & mask;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        sb_t e;
        logic [63:0] r;
        if (rst) begin
            q_main.delete();
        end else if (sb_en) begin
            if (out_valid && out_ready) begin
                if (q_main.size() == 0) begin
                    check("main_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q_main.pop_front();
                    check("main_data", out_data, e.d);
                    check("main_tag", out_tag, e.t);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_shift(in_data, 32, in_amt, in_op);
                q_main.push_back('{d: r[31:0], t: in_tag, cyc: cyc});
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        logic [63:0] r;
        if (rst) begin
            q1.delete(); q5.delete(); q8.delete();
        end else begin
            if (o1_valid) begin
                if (q1.size() == 0) check("s1_unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    check("s1_data", o1_data, e.d); check("s1_tag", o1_tag, e.t);
                    check("s1_latency", cyc - e.cyc, 1); n1++;
                end
            end
            if (o5_valid) begin
                if (q5.size() == 0) check("s5_unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q5.pop_front();
                    check("s5_data", o5_data, e.d); check("s5_tag", o5_tag, e.t);
                    check("s5_latency", cyc - e.cyc, 5); n5++;
                end
            end
            if (o8_valid) begin
                if (q8.size() == 0) check("w8_unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    check("w8_data", {24'h0, o8_data}, e.d); check("w8_tag", o8_tag, e.t);
                    check("w8_latency", cyc - e.cyc, 3); n8++;
                end
            end
            if (s_valid) begin
                r = ref_shift(s_data, 32, s_amt, s_op);
                if (i1_ready) q1.push_back('{d: r[31:0], t: s_tag, cyc: cyc});
                if (i5_ready) q5.push_back('{d: r[31:0], t: s_tag, cyc: cyc});
                r = ref_shift({56'h0, s_data[7:0]}, 8, s_amt[2:0], s_op);
                if (i8_ready) q8.push_back('{d: r[31:0], t: s_tag, cyc: cyc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                         input logic [4:0] t);
        in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = t;
    endtask

    initial begin
        logic [31:0] stall_d;
        logic [4:0]  stall_t;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b1; s_valid = 1'b0; s_data = '0; s_amt = '0; s_op = '0; s_tag = '0;

        vecs[0]  = '{SH_SLL, 32'h0000_0001, 5'd31, 5'd1,  32'h8000_0000};
        vecs[1]  = '{SH_SRL, 32'h8000_0000, 5'd4,  5'd2,  32'h0800_0000};
        vecs[2]  = '{SH_SRA, 32'h8000_0000, 5'd4,  5'd3,  32'hF800_0000};
        vecs[3]  = '{SH_ROL, 32'h8000_0001, 5'd1,  5'd4,  32'h0000_0003};
        vecs[4]  = '{SH_SLL, 32'hDEAD_BEEF, 5'd0,  5'd5,  32'hDEAD_BEEF};
        vecs[5]  = '{SH_SRL, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF};
        vecs[6]  = '{SH_SRA, 32'hDEAD_BEEF, 5'd0,  5'd7,  32'hDEAD_BEEF};
        vecs[7]  = '{SH_ROL, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF};
        vecs[8]  = '{SH_SRA, 32'h7FFF_FFFF, 5'd31, 5'd9,  32'h0000_0000};
        vecs[9]  = '{SH_ROL, 32'h1234_5678, 5'd8,  5'd10, 32'h3456_7812};
        vecs[10] = '{SH_SRA, 32'hF000_0000, 5'd31, 5'd11, 32'hFFFF_FFFF};
        vecs[11] = '{SH_SLL, 32'hDEAD_BEEF, 5'd16, 5'd12, 32'hBEEF_0000};

        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].tag);
            @(negedge clk); check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk); check($sformatf("vec%0d_early_valid", i), out_valid, 0);
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
        end

        // Back-to-back stream: 100 results must drain at one per cycle.
        @(posedge clk); #1;
        sb_en = 1'b1; n_out = 0;
        for (int i = 0; i < 100; i++) begin
            drive(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 5'(i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check("stream_count", n_out, 100);

        // Backpressure: three ops, then a three-cycle stall with a fourth op waiting.
        @(posedge clk); #1;
        n_out = 0;
        drive(SH_SLL, 32'h0000_00FF, 5'd4, 5'd20); @(posedge clk); #1;
        drive(SH_SRA, 32'h8000_0000, 5'd1, 5'd21); @(posedge clk); #1;
        drive(SH_ROL, 32'hF000_000F, 5'd4, 5'd22); @(posedge clk); #1;
        out_ready = 1'b0;
        drive(SH_SRL, 32'hFFFF_FFFF, 5'd28, 5'd23);
        @(negedge clk);
        stall_d = out_data; stall_t = out_tag;
        check("stall_head_data", out_data, 32'hC000_0000);
        check("stall_head_tag", out_tag, 21);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("stall%0d_in_ready", i), in_ready, 0);
            check($sformatf("stall%0d_out_valid", i), out_valid, 1);
            check($sformatf("stall%0d_data_stable", i), out_data, stall_d);
            check($sformatf("stall%0d_tag_stable", i), out_tag, stall_t);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check("stall_drain_count", n_out, 4);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        drive(SH_SLL, 32'h0000_0003, 5'd2, 5'd30); @(posedge clk); #1;
        drive(SH_ROL, 32'hAAAA_5555, 5'd3, 5'd31); @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_out_data", out_data, 0);
        check("rst_async_out_tag", out_tag, 0);
        check("rst_async_in_ready", in_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_stale%0d", i), out_valid, 0);
        end
        check("rst_in_ready_after", in_ready, 1);
        sb_en = 1'b0;

        // Parameter sweep: continuous random stream into the three alternate builds.
        @(posedge clk); #1;
        n1 = 0; n5 = 0; n8 = 0;
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'b1; s_data = $urandom; s_amt = 5'($urandom_range(0, 31));
            s_op = 2'($urandom_range(0, 3)); s_tag = 5'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("sweep_s1_count", n1, 60);
        check("sweep_s5_count", n5, 60);
        check("sweep_w8_count", n8, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
